counter_display_driver: RTL and testbench
=========================================

COUNTER_DISPLAY_DRIVER -- requirements
Module: counter_display_driver

Interface
REQ-001 Parameter N, default 16, SHALL be the width of the binary value input.
REQ-002 Parameter DIGITS, default 8, SHALL be the number of multiplexed 7-segment digits.
REQ-003 Parameter REFRESH_DIV, default 100000, SHALL be the clock cycles each digit stays active; minimum 2.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on posedge clock.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset, sampled on posedge clock.
REQ-006 counterN  in  N  SHALL be the binary value to display, from the upstream counter.
REQ-007 threshold  in  1  SHALL be the upstream threshold flag, shown on the digit-0 decimal point.
REQ-008 seg  out  7  SHALL be the active-low segments, bit0=CA … bit6=CG.
REQ-009 dp  out  1  SHALL be the active-low decimal point.
REQ-010 anodes  out  DIGITS  SHALL be the active-low one-hot digit enables, bit0 = rightmost digit.
REQ-011 conv_done  out  1  SHALL pulse high for one cycle when a new value is latched for display.

Function
REQ-012 The converter FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE SHALL last one cycle, capture counterN and threshold, clear the work register and go to SHIFT.
REQ-014 SHIFT SHALL run exactly N cycles of shift-and-add-3; each cycle SHALL add 3 to every 4-bit field >=5, then shift left 1 with the next MSB of the capture.
REQ-015 DONE SHALL last one cycle, copy the work digits and captured threshold into the display register, assert conv_done, then return to IDLE.
REQ-016 Conversion period SHALL be N+2 cycles; the display register SHALL update exactly N+2 cycles after the IDLE capture.
REQ-017 counterN changes during SHIFT/DONE SHALL NOT affect the conversion in flight; they SHALL be picked up at the next IDLE.
REQ-018 The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap; on wrap the digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-019 seg, dp and anodes SHALL be registered, so they reflect the digit index with one cycle of latency.
REQ-020 Leading-zero blanking: any digit above the most-significant non-zero digit SHALL show seg=7'h7F; digit 0 SHALL always be shown (value 0 -> "0").
REQ-021 dp SHALL be 0 only when digit 0 is active and the displayed threshold is 1; otherwise dp SHALL be 1.
REQ-022 In BCD mode, elaboration SHALL fail if 2**N-1 >= 10**DIGITS; in hex mode, it SHALL fail if N > 4*DIGITS.

Reset
REQ-023 On reset: FSM SHALL be IDLE, refresh counter and digit index 0, display register and displayed threshold 0, conv_done 0, anodes all 1, seg 7'h7F, dp 1.
REQ-024 Reset during SHIFT SHALL abort the conversion; the display register SHALL NOT be updated by the aborted conversion.

Configuration
REQ-025 With DISPLAY_BCD_EN defined, the display SHALL be decimal using the REQ-014 converter.
REQ-026 Without DISPLAY_BCD_EN, the display SHALL be hexadecimal: SHIFT SHALL copy the capture unchanged (no add-3); period and conv_done timing SHALL be unchanged; digits SHALL be decoded 0-F.

Structure
REQ-027 Package counter_display_pkg SHALL hold the FSM state enum and the 16-entry active-low segment table (0-F).
REQ-028 Sub-module seven_seg_decoder (4-bit nibble -> 7-bit active-low seg, combinational, using the package table) SHALL be instantiated once on the selected digit.

Verification (N=16, DIGITS=8, REFRESH_DIV=4, BCD unless stated)
REQ-029 Assert reset 3 cycles -> anodes=8'hFF, seg=7'h7F, dp=1, conv_done=0; 1 cycle after release -> anodes=8'hFE.
REQ-030 counterN=1234 -> conv_done 18 cycles after capture; scan shows digit0=7'h19 ("4"), digit1="3", digit2="2", digit3="1", digits4-7=7'h7F.
REQ-031 counterN=65535 -> digits 5,3,5,5,6 (digit0 upward); counterN=0 -> digit0=7'h40, others 7'h7F.
REQ-032 counterN=100, switched to 200 on the 5th SHIFT cycle -> first conv_done displays 100, next conv_done displays 200.
REQ-033 Free run -> anodes FE,FD,FB,F7,EF,DF,BF,7F,FE, each held 4 cycles; threshold=1 -> dp=0 only while anodes=FE.
REQ-034 Reset on the 8th SHIFT cycle with 999 displayed and 4321 in flight -> display cleared; first conv_done after release shows the new counterN; no 4321 is shown.
REQ-035 Hex build (no DISPLAY_BCD_EN), counterN=16'hBEEF -> digits F,E,E,B; conv_done period 18.

Source files
------------

// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter display driver:
// converter FSM states and the active-low 7-segment glyph table (bit0=CA .. bit6=CG).
package counter_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Glyphs 0-F, segment active when its bit is 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/counter_display_driver_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
module seven_seg_decoder
  import counter_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup, no blanking here.
  always_comb seg = seg_of(nibble);

endmodule

// File: rtl/counter_display_driver.sv
// Multiplexed 7-segment display driver for an upstream binary counter.
// A converter FSM (IDLE, SHIFT x N, DONE) refreshes the display register every
// N+2 cycles; a refresh counter scans the digits with leading-zero blanking.
// Build option DISPLAY_BCD_EN: decimal display via shift-and-add-3; when
// undefined the display is hexadecimal (plain shift, same timing).
module counter_display_driver
  import counter_display_pkg::*;
#(
  parameter int N           = 16,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      counterN,
  input  logic              threshold,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] anodes,
  output logic              conv_done
);

  localparam int WORK_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  // Elaboration-time range checks.
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end
`ifdef DISPLAY_BCD_EN
  localparam real BIN_MAX = (2.0 ** N) - 1.0;
  localparam real DEC_LIM = 10.0 ** DIGITS;
  if (BIN_MAX >= DEC_LIM) begin : g_bad_bcd
    $error("DIGITS too small for decimal display of N bits");
  end
`else
  if (N > 4 * DIGITS) begin : g_bad_hex
    $error("DIGITS too small for hex display of N bits");
  end
`endif

  conv_state_t       state, next_state;
  logic [N-1:0]      cap;
  logic              cap_thr;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shift_src;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORK_W-1:0] disp_digits;
  logic              disp_thr;

  logic [REF_W-1:0]  refresh;
  logic [IDX_W-1:0]  digit;
  logic [3:0]        sel_nibble;
  logic              upper_zero;
  logic              blank;
  logic [6:0]        digit_seg;

`ifdef DISPLAY_BCD_EN
  // Double-dabble correction: every BCD field >= 5 gets +3 before the shift.
  function automatic logic [WORK_W-1:0] add3(input logic [WORK_W-1:0] v);
    logic [WORK_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign shift_src = add3(work);
`else
  assign shift_src = work;
`endif

  // Converter state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Converter next-state: one IDLE, N SHIFT, one DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(N - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift counter, restarted on every IDLE.
  always_ff @(posedge clock) begin
    if (reset)               bit_cnt <= '0;
    else if (state == IDLE)  bit_cnt <= '0;
    else if (state == SHIFT) bit_cnt <= bit_cnt + 1'b1;
  end

  // Conversion datapath: capture is frozen after IDLE so input changes wait.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        cap     <= counterN;
        cap_thr <= threshold;
        work    <= '0;
      end
      SHIFT: begin
        cap  <= cap << 1;
        work <= (shift_src << 1) | WORK_W'(cap[N-1]);
      end
      default: ;
    endcase
  end

  // Display register commit; an aborted conversion never reaches DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_digits <= '0;
      disp_thr    <= 1'b0;
      conv_done   <= 1'b0;
    end else begin
      conv_done <= (state == DONE);
      if (state == DONE) begin
        disp_digits <= work;
        disp_thr    <= cap_thr;
      end
    end
  end

  // Refresh divider and digit index scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh <= '0;
      digit   <= '0;
    end else if (refresh == REF_W'(REFRESH_DIV - 1)) begin
      refresh <= '0;
      digit   <= (digit == IDX_W'(DIGITS - 1)) ? '0 : digit + 1'b1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  // Select the active nibble; blank it if it and everything above is zero.
  always_comb begin
    sel_nibble = 4'd0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == digit) sel_nibble = disp_digits[4*i +: 4];
      if ((IDX_W'(i) >= digit) && (disp_digits[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    blank = (digit != '0) && upper_zero;
  end

  seven_seg_decoder u_dec (
    .nibble (sel_nibble),
    .seg    (digit_seg)
  );

  // Registered display outputs, one cycle behind the digit index.
  always_ff @(posedge clock) begin
    if (reset) begin
      anodes <= '1;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      anodes <= ~(DIGITS'(1) << digit);
      seg    <= blank ? 7'h7F : digit_seg;
      dp     <= !((digit == '0) && disp_thr);
    end
  end

endmodule

// File: tb/tb_counter_display_driver.sv
// Bench for counter_display_driver (N=16, DIGITS=8, REFRESH_DIV=4).
// Follows DISPLAY_BCD_EN the same way as the design: decimal when defined, hex otherwise.
module tb_counter_display_driver;

  localparam int N      = 16;
  localparam int DIGITS = 8;
  localparam int RD     = 4;
  localparam int PER    = N + 2;
`ifdef DISPLAY_BCD_EN
  localparam int unsigned BASE = 10;
`else
  localparam int unsigned BASE = 16;
`endif
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      counterN = '0;
  logic              threshold = 1'b0;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] anodes;
  logic              conv_done;

  int total = 0;
  int bad   = 0;

  counter_display_driver #(.N(N), .DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
    .clock     (clock),
    .reset     (reset),
    .counterN  (counterN),
    .threshold (threshold),
    .seg       (seg),
    .dp        (dp),
    .anodes    (anodes),
    .conv_done (conv_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph expected for digit i of value v: digit i is lit when i==0 or v >= BASE**i.
  function automatic logic [6:0] exp_seg(input int unsigned v, input int i);
    int unsigned p = 1;
    for (int k = 0; k < i; k++) p = p * BASE;
    if (i != 0 && v < p) return BLANK;
    return GLYPH[4'((v / p) % BASE)];
  endfunction

  // Reference model: every PER cycles the value sampled at the start is shown
  // at the end; the digit index advances every RD cycles.
  int          m_phase, m_tick, m_digit;
  int unsigned m_disp, m_cap;
  logic        m_thr, m_cap_thr;
  logic [DIGITS-1:0] e_anodes;
  logic [6:0]  e_seg;
  logic        e_dp, e_done;
  bit          chk_en = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= 0; m_tick <= 0; m_digit <= 0; m_disp <= 0; m_thr <= 1'b0;
      e_anodes <= '1; e_seg <= BLANK; e_dp <= 1'b1; e_done <= 1'b0;
    end else begin
      e_anodes <= ~(DIGITS'(1) << m_digit);
      e_seg    <= exp_seg(m_disp, m_digit);
      e_dp     <= !(m_digit == 0 && m_thr);
      e_done   <= (m_phase == PER - 1);
      if (m_phase == 0) begin
        m_cap     <= counterN;
        m_cap_thr <= threshold;
      end
      if (m_phase == PER - 1) begin
        m_disp <= m_cap;
        m_thr  <= m_cap_thr;
      end
      m_phase <= (m_phase == PER - 1) ? 0 : m_phase + 1;
      if (m_tick == RD - 1) begin
        m_tick  <= 0;
        m_digit <= (m_digit + 1) % DIGITS;
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("mon_anodes", 32'(anodes), 32'(e_anodes));
      check("mon_seg", 32'(seg), 32'(e_seg));
      check("mon_dp", 32'(dp), 32'(e_dp));
      check("mon_conv_done", 32'(conv_done), 32'(e_done));
    end
  end

  task automatic wait_done(input int limit, output int n);
    bit hit = 1'b0;
    n = -1;
    for (int c = 1; c <= limit && !hit; c++) begin
      @(negedge clock);
      if (conv_done) begin
        n = c;
        hit = 1'b1;
      end
    end
  endtask

  task automatic scan(output logic [6:0] got [DIGITS], output logic dp0);
    for (int i = 0; i < DIGITS; i++) got[i] = 7'h55;
    dp0 = 1'bx;
    for (int c = 0; c < DIGITS * RD; c++) begin
      @(negedge clock);
      for (int i = 0; i < DIGITS; i++) begin
        if (anodes == ~(DIGITS'(1) << i)) begin
          got[i] = seg;
          if (i == 0) dp0 = dp;
        end
      end
    end
  endtask

  typedef struct {
    logic [15:0]      value;
    logic             thr;
    logic [7:0][6:0]  segs;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [6:0] got [DIGITS];
    logic       dp0;
    int         n, first, second;
    logic [15:0] pair_a [2];
    logic [15:0] pair_b [2];

    vecs[0] = '{16'd1234,  1'b0, 56'h0};
    vecs[1] = '{16'd65535, 1'b1, 56'h0};
    vecs[2] = '{16'd0,     1'b1, 56'h0};
    vecs[3] = '{16'd100,   1'b0, 56'h0};
`ifdef DISPLAY_BCD_EN
    vecs[0].segs = {BLANK, BLANK, BLANK, BLANK, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1].segs = {BLANK, BLANK, BLANK, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12};
    vecs[2].segs = {BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, 7'h40};
    vecs[3].segs = {BLANK, BLANK, BLANK, BLANK, BLANK, 7'h79, 7'h40, 7'h40};
    vecs[4] = '{16'd9078, 1'b1, {BLANK, BLANK, BLANK, BLANK, 7'h10, 7'h40, 7'h78, 7'h00}};
`else
    vecs[0].segs = {BLANK, BLANK, BLANK, BLANK, BLANK, 7'h19, 7'h21, 7'h24};
    vecs[1].segs = {BLANK, BLANK, BLANK, BLANK, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
    vecs[2].segs = {BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, 7'h40};
    vecs[3].segs = {BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, 7'h02, 7'h19};
    vecs[4] = '{16'hBEEF, 1'b1, {BLANK, BLANK, BLANK, BLANK, 7'h03, 7'h06, 7'h06, 7'h0E}};
`endif

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_anodes", 32'(anodes), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_conv_done", 32'(conv_done), 32'h0);

    // Free-running scan order and first conversion latency/period.
    threshold = 1'b1;
    counterN  = 16'd1234;
    reset     = 1'b0;
    first = -1; second = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      check($sformatf("anode_seq%0d", k), 32'(anodes),
            32'(8'(~(8'b1 << ((k / RD) % DIGITS)))));
      if (conv_done) begin
        if (first < 0) first = k + 1;
        else if (second < 0) second = k + 1;
      end
    end
    check("first_done_latency", first, PER);
    check("done_period", second - first, PER);

    // Table of displayed values.
    for (int j = 0; j < 5; j++) begin
      counterN  = vecs[j].value;
      threshold = vecs[j].thr;
      repeat (2 * PER + 2) @(negedge clock);
      scan(got, dp0);
      for (int i = 0; i < DIGITS; i++)
        check($sformatf("vec%0d_digit%0d", j, i), 32'(got[i]), 32'(vecs[j].segs[i]));
      check($sformatf("vec%0d_dp0", j), 32'(dp0), 32'(!vecs[j].thr));
    end

    // Input change in the middle of SHIFT waits for the next capture.
    pair_a[0] = 16'd100;  pair_b[0] = 16'd200;
    pair_a[1] = 16'd4369; pair_b[1] = 16'd8738;
    threshold = 1'b0;
    for (int p = 0; p < 2; p++) begin
      counterN = pair_a[p];
      wait_done(40, n);
      wait_done(40, n);
      check("inflight_sync", n, PER);
      repeat (5) @(negedge clock);
      counterN = pair_b[p];
      wait_done(40, n);
      check("inflight_old_done", n, PER - 5);
      wait_done(40, n);
      check("inflight_new_done", n, PER);
    end

    // Reset on the 8th SHIFT cycle aborts the in-flight conversion.
    counterN = 16'd999;
    repeat (3) wait_done(40, n);
    counterN = 16'd4321;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    counterN = 16'd2468;
    repeat (2) @(negedge clock);
    check("abort_anodes", 32'(anodes), 32'hFF);
    check("abort_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    wait_done(40, n);
    check("abort_first_done", n, PER);
    repeat (RD) @(negedge clock);
    scan(got, dp0);
    for (int i = 0; i < DIGITS; i++)
      check($sformatf("abort_digit%0d", i), 32'(got[i]), 32'(exp_seg(2468, i)));

    // Random values, threshold toggles and occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) counterN = N'($urandom);
      if ($urandom_range(0, 9) == 0) threshold = 1'($urandom);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
